// File: rtl/consmax_pkg.sv
`default_nettype none
// consmax_pkg: shared widths, bf16 bias and LUT word layout for the ConSmax bus unit.
package consmax_pkg;
  localparam int IDATA_BIT  = 8;
  localparam int ODATA_BIT  = 8;
  localparam int CDATA_BIT  = 8;
  localparam int EXP_BIT    = 8;
  localparam int MAT_BIT    = 7;
  localparam int LUT_DATA   = EXP_BIT + MAT_BIT + 1;
  localparam int LUT_ADDR   = IDATA_BIT >> 1;
  localparam int LUT_DEPTH  = 2 ** LUT_ADDR;
  localparam int GBUS_DATA  = 32;
  localparam int GBUS_WIDTH = GBUS_DATA / IDATA_BIT;
  localparam int NUM_HEAD   = 8;
  localparam int BF16_BIAS  = 127;

  typedef struct packed {
    logic               sign;
    logic [EXP_BIT-1:0] exp;
    logic [MAT_BIT-1:0] mant;
  } lut_word_t;
endpackage
`default_nettype wire

// File: rtl/consmax_lane.sv
`default_nettype none
// consmax_lane: one lane's 2-stage pipe -- bf16 product of two LUT words,
// power-of-two down-shift and saturation to a signed 8-bit integer.
module consmax_lane
  import consmax_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  lut_word_t            hi_word,
  input  lut_word_t            lo_word,
  input  logic [CDATA_BIT-1:0] shift,
  input  logic                 in_valid,
  output logic [ODATA_BIT-1:0] out_data,
  output logic                 out_valid
);
  lut_word_t            s1_a;
  lut_word_t            s1_b;
  logic [CDATA_BIT-1:0] s1_shift;
  logic                 s1_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_shift <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_a     <= hi_word;
      s1_b     <= lo_word;
      s1_shift <= shift;
      s1_valid <= in_valid;
    end
  end

  logic [15:0]        prod;
  logic               norm;
  logic [6:0]         mant;
  logic signed [11:0] exp_r;
  logic signed [11:0] e_int;
  logic               zero;
  logic               ovf;
  logic [7:0]         frac;
  logic [6:0]         mag;
  logic [7:0]         mag8;
  logic [7:0]         result;

  always_comb begin
    prod  = {8'd0, 1'b1, s1_a.mant} * {8'd0, 1'b1, s1_b.mant};
    norm  = prod[15];
    mant  = norm ? prod[14:8] : prod[13:7];
    exp_r = 12'(s1_a.exp) + 12'(s1_b.exp) + 12'(norm) - 12'(BF16_BIAS);
    // Unbiased exponent of the shifted product; 1.m * 2^e_int is the magnitude.
    e_int = exp_r - 12'(BF16_BIAS) - 12'(s1_shift);
    zero  = (s1_a.exp == '0) || (s1_b.exp == '0);
    ovf   = (s1_a.exp == '1) || (s1_b.exp == '1) || (exp_r > 12'sd254);
    frac  = {1'b1, mant} >> (3'd7 - e_int[2:0]);
    mag   = 7'd0;
    if (zero)                   mag = 7'd0;
    else if (ovf)               mag = 7'd127;
    else if (e_int < 12'sd0)    mag = 7'd0;
    else if (e_int >= 12'sd7)   mag = 7'd127;
    else                        mag = frac[6:0];
    mag8   = {1'b0, mag};
    result = (s1_a.sign ^ s1_b.sign) ? (~mag8 + 8'd1) : mag8;
  end

  logic unused_bits;
  assign unused_bits = ^{prod[6:0], frac[7]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= result;
    end
  end
endmodule
`default_nettype wire

// File: rtl/consmax_bus.sv
`default_nettype none
// consmax_bus: shared programmable LO/HI exponent LUTs feeding NUM_HEAD x GBUS_WIDTH
// ConSmax lanes on the global bus.
module consmax_bus
  import consmax_pkg::*;
(
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [CDATA_BIT-1:0]           cfg_consmax_shift,
  input  logic [LUT_ADDR:0]              lut_waddr,
  input  logic                           lut_wen,
  input  logic [LUT_DATA-1:0]            lut_wdata,
  input  logic [GBUS_DATA*NUM_HEAD-1:0]  idata,
  input  logic [NUM_HEAD-1:0]            idata_valid,
  output logic [GBUS_DATA*NUM_HEAD-1:0]  odata,
  output logic [GBUS_WIDTH*NUM_HEAD-1:0] odata_valid
);
  lut_word_t lut_lo [LUT_DEPTH];
  lut_word_t lut_hi [LUT_DEPTH];

  // Lookups are combinational off the registers, so a same-cycle write is seen next cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_lo[i] <= '0;
        lut_hi[i] <= '0;
      end
    end else if (lut_wen) begin
      if (lut_waddr[LUT_ADDR]) lut_hi[lut_waddr[LUT_ADDR-1:0]] <= lut_wdata;
      else                     lut_lo[lut_waddr[LUT_ADDR-1:0]] <= lut_wdata;
    end
  end

  for (genvar h = 0; h < NUM_HEAD; h++) begin : g_head
    for (genvar l = 0; l < GBUS_WIDTH; l++) begin : g_lane
      logic [IDATA_BIT-1:0] code;
      assign code = idata[h*GBUS_DATA + l*IDATA_BIT +: IDATA_BIT];

      consmax_lane u_lane (
        .clk       (clk),
        .rstn      (rstn),
        .hi_word   (lut_hi[code[IDATA_BIT-1 -: LUT_ADDR]]),
        .lo_word   (lut_lo[code[LUT_ADDR-1:0]]),
        .shift     (cfg_consmax_shift),
        .in_valid  (idata_valid[h]),
        .out_data  (odata[h*GBUS_DATA + l*IDATA_BIT +: IDATA_BIT]),
        .out_valid (odata_valid[h*GBUS_WIDTH + l])
      );
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_consmax_bus.sv
`default_nettype none
// tb_consmax_bus: scoreboard bench for consmax_bus with a bench-side LUT and arithmetic model.
module tb_consmax_bus;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   cfg_consmax_shift = '0;
  logic [4:0]   lut_waddr = '0;
  logic         lut_wen = 1'b0;
  logic [15:0]  lut_wdata = '0;
  logic [255:0] idata = '0;
  logic [7:0]   idata_valid = '0;
  logic [255:0] odata;
  logic [31:0]  odata_valid;

  always #5 clk = ~clk;

  consmax_bus dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_consmax_shift (cfg_consmax_shift),
    .lut_waddr         (lut_waddr),
    .lut_wen           (lut_wen),
    .lut_wdata         (lut_wdata),
    .idata             (idata),
    .idata_valid       (idata_valid),
    .odata             (odata),
    .odata_valid       (odata_valid)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  valid;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [15:0]  m_lo [16];
  logic [15:0]  m_hi [16];
  logic [255:0] m_out;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [7:0] model_lane(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] sh);
    int ea, eb, p, e, mant, mag, s;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 0 || eb == 0) return 8'h00;
    if (ea == 255 || eb == 255) mag = 127;
    else begin
      p = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
      e = ea + eb - 127;
      if (p >= 32768) begin mant = (p >> 8) & 127; e = e + 1; end
      else mant = (p >> 7) & 127;
      if (e > 254) mag = 127;
      else begin
        s = e - 127 - int'(sh) - 7;
        if (s >= 0) mag = 127;
        else if (-s >= 8) mag = 0;
        else mag = (128 + mant) >> (-s);
        if (mag > 127) mag = 127;
      end
    end
    return (a[15] ^ b[15]) ? 8'(-mag) : 8'(mag);
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: drive at negedge, model the edge, push the expected beat, sample at +1.
  task automatic step(input logic [7:0] hv, input logic [255:0] d, input logic [7:0] sh,
                      input logic we, input int wa, input logic [15:0] wd);
    exp_t        e;
    logic [7:0]  code;
    logic [4:0]  w5;
    @(negedge clk);
    idata_valid = hv; idata = d; cfg_consmax_shift = sh;
    lut_wen = we; lut_waddr = 5'(wa); lut_wdata = wd;
    @(posedge clk);
    cyc++;
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin m_lo[i] = '0; m_hi[i] = '0; end
      m_out = '0;
      sb.delete();
    end else begin
      e.valid = '0;
      for (int h = 0; h < 8; h++)
        for (int l = 0; l < 4; l++) begin
          e.valid[h*4+l] = hv[h];
          if (hv[h]) begin
            code = d[h*32 + l*8 +: 8];
            m_out[h*32 + l*8 +: 8] = model_lane(m_hi[code[7:4]], m_lo[code[3:0]], sh);
          end
        end
      e.data = m_out;
      e.due  = cyc + 1;
      sb.push_back(e);
      if (we) begin
        w5 = 5'(wa);
        if (w5[4]) m_hi[w5[3:0]] = wd;
        else       m_lo[w5[3:0]] = wd;
      end
    end
    #1;
  endtask

  task automatic load_lut(input int a, input logic [15:0] w);
    step(8'h00, '0, 8'd0, 1'b1, a, w);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(8'h00, '0, 8'd0, 1'b0, 0, '0);
    step(8'hFF, rand_data(), 8'd0, 1'b0, 0, '0);
    checks++;
    if (odata !== '0 || odata_valid !== '0) begin
      failures++;
      $display("FAIL reset odata=%h valid=%h required 0", odata, odata_valid);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    for (int a = 0; a < 16; a++) load_lut(a, 16'h3F80);
    for (int a = 16; a < 32; a++) load_lut(a, 16'h4000);
    step(8'hFF, {32{8'h5A}}, 8'd0, 1'b0, 0, '0);
    checks++;
    if (odata_valid !== '0) begin
      failures++;
      $display("FAIL basic_early valid=%h required 0", odata_valid);
    end
    for (int k = 0; k < 2; k++) begin
      step(8'h00, '0, 8'd0, 1'b0, 0, '0);
      if (k == 0) begin
        checks++;
        if (odata_valid !== '1 || odata !== {32{8'h02}}) begin
          failures++;
          $display("FAIL basic_latency odata=%h valid=%h required all 02 / all ones", odata, odata_valid);
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front(); checks++;
        if (odata !== e.data || odata_valid !== e.valid) begin
          failures++;
          $display("FAIL basic_sb cyc=%0d odata=%h valid=%h required %h / %h", cyc, odata, odata_valid, e.data, e.valid);
        end
      end
    end
  endtask

  task automatic test_shift();
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) step(8'hFF, rand_data(), 8'(k % 4), 1'b0, 0, '0);
      else       step(8'h00, '0, 8'd0, 1'b0, 0, '0);
      if (k >= 1 && k <= 8 && ((k - 1) % 4) == 1) begin
        checks++;
        if (odata !== {32{8'h01}}) begin
          failures++;
          $display("FAIL shift1 odata=%h required all 01", odata);
        end
      end
      if (k >= 1 && k <= 8 && ((k - 1) % 4) == 2) begin
        checks++;
        if (odata !== '0) begin
          failures++;
          $display("FAIL shift2 odata=%h required all 00", odata);
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front(); checks++;
        if (odata !== e.data || odata_valid !== e.valid) begin
          failures++;
          $display("FAIL shift_sb cyc=%0d odata=%h valid=%h required %h / %h", cyc, odata, odata_valid, e.data, e.valid);
        end
      end
    end
  endtask

  task automatic test_sat_sign();
    exp_t       e;
    logic [7:0] want [2];
    logic [15:0] hw [2];
    want[0] = 8'h7F; want[1] = 8'h81;
    hw[0] = 16'h4300; hw[1] = 16'hC300;
    for (int t = 0; t < 2; t++) begin
      load_lut(19, hw[t]);
      step(8'hFF, {32{8'h34}}, 8'd0, 1'b0, 0, '0);
      step(8'h00, '0, 8'd0, 1'b0, 0, '0);
      checks++;
      if (odata !== {32{want[t]}}) begin
        failures++;
        $display("FAIL sat_sign%0d odata=%h required all %h", t, odata, want[t]);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front(); checks++;
        if (odata !== e.data || odata_valid !== e.valid) begin
          failures++;
          $display("FAIL sat_sb cyc=%0d odata=%h valid=%h required %h / %h", cyc, odata, odata_valid, e.data, e.valid);
        end
      end
    end
  endtask

  task automatic test_zero_inf();
    exp_t       e;
    logic [7:0] codes [5];
    logic [7:0] want  [5];
    codes[0] = 8'h30; want[0] = 8'h00;
    codes[1] = 8'h5A; want[1] = 8'h7F;
    codes[2] = 8'h6A; want[2] = 8'h81;
    codes[3] = 8'h71; want[3] = 8'h7F;
    codes[4] = 8'h8A; want[4] = 8'h00;
    load_lut(0, 16'h0000);
    load_lut(21, 16'h7F80);
    load_lut(22, 16'hFF80);
    load_lut(23, 16'h7F00);
    load_lut(1, 16'h4000);
    load_lut(24, 16'h3B80);
    for (int k = 0; k < 7; k++) begin
      if (k < 5) step(8'hFF, {32{codes[k]}}, 8'd0, 1'b0, 0, '0);
      else       step(8'h00, '0, 8'd0, 1'b0, 0, '0);
      if (k >= 1 && k <= 5) begin
        checks++;
        if (odata !== {32{want[k-1]}}) begin
          failures++;
          $display("FAIL zero_inf code=%h odata=%h required all %h", codes[k-1], odata, want[k-1]);
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front(); checks++;
        if (odata !== e.data || odata_valid !== e.valid) begin
          failures++;
          $display("FAIL zero_inf_sb cyc=%0d odata=%h valid=%h required %h / %h", cyc, odata, odata_valid, e.data, e.valid);
        end
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    for (int k = 0; k < 35; k++) begin
      if (k < 32)       step(8'hFF, rand_data(), 8'd0, 1'b1, k, 16'h3C00 + 16'(k << 7));
      else if (k == 32) step(8'hFF, '0, 8'd0, 1'b1, 32, 16'h4080);
      else if (k == 33) step(8'hFF, '0, 8'd0, 1'b0, 0, '0);
      else              step(8'h00, '0, 8'd0, 1'b0, 0, '0);
      if (k == 33) begin
        checks++;
        if (odata !== {32{8'h04}}) begin
          failures++;
          $display("FAIL collision_old odata=%h required all 04", odata);
        end
      end
      if (k == 34) begin
        checks++;
        if (odata !== {32{8'h7F}}) begin
          failures++;
          $display("FAIL wrap_new odata=%h required all 7f", odata);
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front(); checks++;
        if (odata !== e.data || odata_valid !== e.valid) begin
          failures++;
          $display("FAIL collision_sb cyc=%0d odata=%h valid=%h required %h / %h", cyc, odata, odata_valid, e.data, e.valid);
        end
      end
    end
  endtask

  task automatic test_head_valid();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (k == 0)      step(8'hFF, {32{8'h00}}, 8'd0, 1'b0, 0, '0);
      else if (k == 1) step(8'h05, {32{8'h01}}, 8'd0, 1'b0, 0, '0);
      else             step(8'h00, rand_data(), 8'd0, 1'b0, 0, '0);
      if (k == 2) begin
        checks++;
        if (odata_valid !== 32'h0000_0F0F || odata[63:0] !== {{4{8'h7F}}, {4{8'h08}}}) begin
          failures++;
          $display("FAIL head_valid valid=%h lanes0-1=%h required 00000f0f / 7f7f7f7f08080808", odata_valid, odata[63:0]);
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front(); checks++;
        if (odata !== e.data || odata_valid !== e.valid) begin
          failures++;
          $display("FAIL head_sb cyc=%0d odata=%h valid=%h required %h / %h", cyc, odata, odata_valid, e.data, e.valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      step(8'($urandom), rand_data(), 8'($urandom_range(0, 3)), 1'b0, 0, '0);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front(); checks++;
        if (odata !== e.data || odata_valid !== e.valid) begin
          failures++;
          $display("FAIL stream_sb cyc=%0d odata=%h valid=%h required %h / %h", cyc, odata, odata_valid, e.data, e.valid);
        end
      end
    end
    rstn = 1'b0;
    step(8'hFF, rand_data(), 8'd0, 1'b1, 16, 16'h3F80);
    checks++;
    if (odata !== '0 || odata_valid !== '0) begin
      failures++;
      $display("FAIL reset_mid odata=%h valid=%h required 0", odata, odata_valid);
    end
    rstn = 1'b1;
    step(8'hFF, rand_data(), 8'd0, 1'b0, 0, '0);
    checks++;
    if (odata_valid !== '0) begin
      failures++;
      $display("FAIL reset_drop valid=%h required 0", odata_valid);
    end
    step(8'h00, '0, 8'd0, 1'b0, 0, '0);
    checks++;
    if (odata !== '0 || odata_valid !== '1) begin
      failures++;
      $display("FAIL reset_lut odata=%h valid=%h required 0 / all ones", odata, odata_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_sat_sign();
    test_zero_inf();
    test_collision();
    test_head_valid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
